// File: rtl/crop_pkg.sv
// Shared state encoding and constants for the multi-window stream cropper.
package crop_pkg;

  localparam int unsigned CW_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/crop_out_slot.sv
// One crop window: window/TLAST compare on the raster position and a
// one-deep AXI-stream output register.
module crop_out_slot
  import crop_pkg::*;
#(
  parameter int unsigned FP_TOTAL = 16,
  parameter int unsigned CW       = CW_DEFAULT,
  parameter int unsigned OUT_ROWS = 48,
  parameter int unsigned OUT_COLS = 48
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                en,
  input  logic [CW-1:0]       org_y,
  input  logic [CW-1:0]       org_x,
  input  logic [CW-1:0]       row,
  input  logic [CW-1:0]       col,
  input  logic                in_beat,
  input  logic [FP_TOTAL-1:0] in_data,
  input  logic                out_tready,
  output logic                hit_c,
  output logic                free_c,
  output logic [FP_TOTAL-1:0] out_tdata,
  output logic                out_tvalid,
  output logic                out_tlast
);

  localparam int unsigned EW = CW + 1;

  logic [EW-1:0]       y_e, x_e, y_end, x_end, row_e, col_e;
  logic                last_c;
  logic [FP_TOTAL-1:0] tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;

  // Window bounds are widened by one bit so origin+size cannot wrap.
  always_comb begin
    y_e    = EW'(org_y);
    x_e    = EW'(org_x);
    y_end  = y_e + EW'(OUT_ROWS);
    x_end  = x_e + EW'(OUT_COLS);
    row_e  = EW'(row);
    col_e  = EW'(col);
    hit_c  = en && (row_e >= y_e) && (row_e < y_end) &&
             (col_e >= x_e) && (col_e < x_end);
    last_c = (row_e == y_end - EW'(1)) && (col_e == x_end - EW'(1));
    free_c = !tvalid_q || out_tready;
  end

  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    if (in_beat && hit_c) begin
      tdata_d  = in_data;
      tvalid_d = 1'b1;
      tlast_d  = last_c;
    end else if (out_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign out_tdata  = tdata_q;
  assign out_tvalid = tvalid_q;
  assign out_tlast  = tlast_q;

endmodule

// File: rtl/stream_crop_multi.sv
// Splits one raster pixel stream into NUM_CROPS cropped AXI streams under
// HLS-style start/ready/done/idle control.
module stream_crop_multi
  import crop_pkg::*;
#(
  parameter int unsigned FP_TOTAL  = 16,
  parameter int unsigned IN_ROWS   = 100,
  parameter int unsigned IN_COLS   = 160,
  parameter int unsigned OUT_ROWS  = 48,
  parameter int unsigned OUT_COLS  = 48,
  parameter int unsigned NUM_CROPS = 5,
  parameter int unsigned CW        = CW_DEFAULT
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          ap_start,
  output logic                          ap_ready,
  output logic                          ap_done,
  output logic                          ap_idle,
  input  logic [NUM_CROPS*CW-1:0]       crop_y,
  input  logic [NUM_CROPS*CW-1:0]       crop_x,
  output logic [NUM_CROPS-1:0]          cfg_err,
  input  logic [FP_TOTAL-1:0]           in_TDATA,
  input  logic                          in_TVALID,
  output logic                          in_TREADY,
  output logic [NUM_CROPS*FP_TOTAL-1:0] out_TDATA,
  output logic [NUM_CROPS-1:0]          out_TVALID,
  output logic [NUM_CROPS-1:0]          out_TLAST,
  input  logic [NUM_CROPS-1:0]          out_TREADY
);

  localparam int unsigned EW = CW + 1;

  state_e                  state_q, state_d;
  logic [CW-1:0]           row_q, row_d, col_q, col_d;
  logic [NUM_CROPS*CW-1:0] org_y_q, org_y_d, org_x_q, org_x_d;
  logic [NUM_CROPS-1:0]    cfg_err_q, cfg_err_d, cfg_err_c;
  logic                    ap_ready_q, ap_ready_d;
  logic [NUM_CROPS-1:0]    hit, free;
  logic                    in_beat;

  // Origin fit check on the live inputs, captured only at frame start.
  always_comb begin
    for (int k = 0; k < NUM_CROPS; k++) begin
      cfg_err_c[k] = (EW'(crop_y[k*CW +: CW]) + EW'(OUT_ROWS) > EW'(IN_ROWS)) ||
                     (EW'(crop_x[k*CW +: CW]) + EW'(OUT_COLS) > EW'(IN_COLS));
    end
  end

  // Stall only when a window that wants this pixel still holds an unsent beat.
  assign in_TREADY = (state_q == ST_RUN) && (&(~hit | free));
  assign in_beat   = in_TVALID && in_TREADY;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    org_y_d    = org_y_q;
    org_x_d    = org_x_q;
    cfg_err_d  = cfg_err_q;
    ap_ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          org_y_d    = crop_y;
          org_x_d    = crop_x;
          cfg_err_d  = cfg_err_c;
          ap_ready_d = 1'b1;
          row_d      = '0;
          col_d      = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_beat) begin
          if (col_q == CW'(IN_COLS - 1)) begin
            col_d = '0;
            if (row_q == CW'(IN_ROWS - 1)) begin
              row_d   = '0;
              state_d = ST_DRAIN;
            end else begin
              row_d = row_q + CW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (out_TVALID == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      org_y_q    <= '0;
      org_x_q    <= '0;
      cfg_err_q  <= '0;
      ap_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      org_y_q    <= org_y_d;
      org_x_q    <= org_x_d;
      cfg_err_q  <= cfg_err_d;
      ap_ready_q <= ap_ready_d;
    end
  end

  assign ap_ready = ap_ready_q;
  assign ap_done  = (state_q == ST_DONE);
  assign ap_idle  = (state_q == ST_IDLE);
  assign cfg_err  = cfg_err_q;

  for (genvar k = 0; k < NUM_CROPS; k++) begin : g_slot
    crop_out_slot #(
      .FP_TOTAL (FP_TOTAL),
      .CW       (CW),
      .OUT_ROWS (OUT_ROWS),
      .OUT_COLS (OUT_COLS)
    ) u_slot (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .en         (!cfg_err_q[k]),
      .org_y      (org_y_q[k*CW +: CW]),
      .org_x      (org_x_q[k*CW +: CW]),
      .row        (row_q),
      .col        (col_q),
      .in_beat    (in_beat),
      .in_data    (in_TDATA),
      .out_tready (out_TREADY[k]),
      .hit_c      (hit[k]),
      .free_c     (free[k]),
      .out_tdata  (out_TDATA[k*FP_TOTAL +: FP_TOTAL]),
      .out_tvalid (out_TVALID[k]),
      .out_tlast  (out_TLAST[k])
    );
  end

endmodule
